// File: rtl/ofdm_demod_param.sv
// ofdm_demod_param: reads one OFDM symbol's FFT bins from BSRAM, re-references
// each data bin against the latest pilot and slices BPSK/QPSK bits into res.
// Build option: define OFDM_DEMOD_QPSK_EN to honour the qpsk input and build
// the imaginary path; otherwise only BPSK is built and res upper half is 0.
module ofdm_demod_param #(
  parameter int          ADDR_W        = 11,
  parameter int          BIN_FIRST     = 20,
  parameter int          BIN_LAST      = 120,
  parameter int          PILOT_SPACING = 33,
  parameter logic [15:0] PILOT_AMP     = 16'h4000,
  parameter logic [7:0]  SYNC_BYTE     = 8'h55,
  parameter int          RD_LAT        = 2,
  localparam int         NB            = BIN_LAST - BIN_FIRST + 1,
  localparam int         N_PIL         = (NB >= 2) ? 2 + (NB - 2) / PILOT_SPACING : 1,
  localparam int         N_DATA        = NB - N_PIL
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  qpsk,
  output logic                  busy,
  output logic                  finish,
  output logic                  success,
  output logic [7:0]            nbits,
  output logic [2*N_DATA-1:0]   res,
  input  logic [31:0]           dout,
  output logic                  ce,
  output logic                  oce,
  output logic [ADDR_W-1:0]     ad
);

`ifdef OFDM_DEMOD_QPSK_EN
  localparam int RES_W = 2 * N_DATA;
`else
  localparam int RES_W = N_DATA;
`endif
  localparam int RIW    = $clog2(RES_W);
  localparam int STAGES = RD_LAT - 1;
  localparam int SPW    = $clog2(PILOT_SPACING + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic                first_q;
  logic [SPW-1:0]      sp_cnt;
  logic [STAGES:0]     vld_pipe, pil_pipe, last_pipe;
  logic [STAGES+1:0]   vld_sh, pil_sh, last_sh;
  logic [15:0]         pref_re;
  logic [RIW-1:0]      j_q;
  logic [RES_W-1:0]    res_q;
  logic                success_q;
  logic                accept, issue, issue_pil, issue_last, cons, cons_last;
  logic [15:0]         d_re, diff_re;
  logic                b_re, sync_ok;
  logic [7:0]          top_byte;

  assign accept     = (state_q == IDLE) && start;
  assign issue      = (state_q == ISSUE);
  assign issue_pil  = first_q || (sp_cnt == '0);
  assign issue_last = (ad == ADDR_W'(BIN_LAST));
  assign cons       = vld_pipe[STAGES];
  assign cons_last  = cons && last_pipe[STAGES];

  assign d_re    = dout[31:16];
  assign diff_re = d_re - pref_re;
  assign b_re    = ~diff_re[15];

`ifdef OFDM_DEMOD_QPSK_EN
  logic        q_mode;
  logic [15:0] pref_im, d_im, diff_im;
  logic        b_im;
  assign d_im     = dout[15:0];
  assign diff_im  = d_im - pref_im;
  assign b_im     = ~diff_im[15];
  assign top_byte = q_mode ? res_q[2*N_DATA-1 -: 8] : res_q[N_DATA-1 -: 8];
  assign res      = res_q;
`else
  logic unused_in;
  assign unused_in = ^{qpsk, dout[15:0]};
  assign top_byte  = res_q[N_DATA-1 -: 8];
  assign res       = {{N_DATA{1'b0}}, res_q};
`endif

  assign sync_ok = (res_q[7:0] == SYNC_BYTE) && (top_byte == SYNC_BYTE);

  // Status outputs decode directly from state; success shows the live check in DONE.
  assign busy    = (state_q == ISSUE) || (state_q == DRAIN);
  assign ce      = busy;
  assign oce     = busy;
  assign finish  = (state_q == DONE);
  assign success = finish ? sync_ok : success_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: issue all bins, wait for the last read to return, pulse done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ISSUE;
      ISSUE:   if (issue_last) state_d = DRAIN;
      DRAIN:   if (cons_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address generator; sp_cnt counts down to the next pilot bin (BIN_FIRST+1 is one too).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ad      <= '0;
      first_q <= 1'b0;
      sp_cnt  <= '0;
    end else if (accept) begin
      ad      <= ADDR_W'(BIN_FIRST);
      first_q <= 1'b1;
      sp_cnt  <= '0;
    end else if (issue && !issue_last) begin
      ad      <= ad + 1'b1;
      first_q <= 1'b0;
      if (!first_q)
        sp_cnt <= (sp_cnt == '0) ? SPW'(PILOT_SPACING - 1) : sp_cnt - 1'b1;
    end
  end

  assign vld_sh  = {vld_pipe,  issue};
  assign pil_sh  = {pil_pipe,  issue_pil};
  assign last_sh = {last_pipe, issue && issue_last};

  // Tag pipeline matching BSRAM read latency: marks valid, pilot and last words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      pil_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe  <= vld_sh[STAGES:0];
      pil_pipe  <= pil_sh[STAGES:0];
      last_pipe <= last_sh[STAGES:0];
    end
  end

  // Datapath: pilots update the reference, data words slice into res MSB-first per byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pref_re   <= '0;
      j_q       <= '0;
      res_q     <= '0;
      success_q <= 1'b0;
      nbits     <= '0;
`ifdef OFDM_DEMOD_QPSK_EN
      pref_im   <= '0;
      q_mode    <= 1'b0;
`endif
    end else if (accept) begin
      pref_re   <= '0;
      j_q       <= '0;
      res_q     <= '0;
      success_q <= 1'b0;
      nbits     <= '0;
`ifdef OFDM_DEMOD_QPSK_EN
      pref_im   <= '0;
      q_mode    <= qpsk;
`endif
    end else begin
      if (cons) begin
        if (pil_pipe[STAGES]) begin
          pref_re <= d_re - PILOT_AMP;
`ifdef OFDM_DEMOD_QPSK_EN
          pref_im <= d_im;
`endif
        end else begin
          res_q[j_q ^ RIW'(7)] <= b_re;
`ifdef OFDM_DEMOD_QPSK_EN
          if (q_mode) begin
            res_q[(j_q + RIW'(1)) ^ RIW'(7)] <= b_im;
            j_q <= j_q + RIW'(2);
          end else begin
            j_q <= j_q + RIW'(1);
          end
`else
          j_q <= j_q + RIW'(1);
`endif
        end
      end
      if (cons_last) begin
`ifdef OFDM_DEMOD_QPSK_EN
        nbits <= q_mode ? 8'(2 * N_DATA) : 8'(N_DATA);
`else
        nbits <= 8'(N_DATA);
`endif
      end
      if (state_q == DONE) success_q <= sync_ok;
    end
  end

endmodule

// File: tb/tb_ofdm_demod_param.sv
// Directed bench for ofdm_demod_param with a 2-cycle BSRAM model.
module tb_ofdm_demod_param;
  logic         clk = 1'b0;
  logic         rst, start, qpsk;
  logic         busy, finish, success, ce, oce;
  logic [7:0]   nbits;
  logic [191:0] res;
  logic [31:0]  dout;
  logic [10:0]  ad;

  logic [31:0]  mem [0:2047];
  logic [31:0]  s1;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ofdm_demod_param dut (
    .clk(clk), .rst(rst), .start(start), .qpsk(qpsk), .busy(busy),
    .finish(finish), .success(success), .nbits(nbits), .res(res),
    .dout(dout), .ce(ce), .oce(oce), .ad(ad)
  );

  // Two-stage BSRAM read model.
  always @(posedge clk) begin
    if (ce)  s1   <= mem[ad];
    if (oce) dout <= s1;
  end

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_pil(input int b);
    return (b == 20) || (b == 21) || (b == 54) || (b == 87) || (b == 120);
  endfunction

  function automatic logic [7:0] pay(input int k);
    return (k == 0 || k == 11) ? 8'h55 : 8'hA5;
  endfunction

  function automatic logic [191:0] rep(input logic [7:0] b, input int n);
    logic [191:0] e;
    e = '0;
    for (int k = 0; k < n; k++) e[8*k +: 8] = b;
    return e;
  endfunction

  function automatic logic [191:0] ones(input int n);
    logic [191:0] e;
    e = '0;
    for (int k = 0; k < n; k++) e[k] = 1'b1;
    return e;
  endfunction

  // Load one symbol into BSRAM; j counts data bins in order.
  task automatic fill(input int mode);
    int j;
    logic [7:0] pb;
    j = 0;
    for (int b = 20; b <= 120; b++) begin
      if (is_pil(b)) begin
        case (mode)
          3, 4:    mem[b] = {16'h3000, 16'h0000};
          6:       mem[b] = (b == 54) ? {16'h3000, 16'h0000} :
                            (b == 87) ? {16'h5000, 16'h0000} : {16'h4000, 16'h0000};
          7:       mem[b] = {16'hC000, 16'h0000};
          default: mem[b] = {16'h4000, 16'h0000};
        endcase
      end else begin
        pb = pay(j / 8);
        case (mode)
          1:       mem[b] = {16'h6000, 16'h0000};
          2:       mem[b] = {pb[7 - (j % 8)] ? 16'h2000 : 16'hE000, 16'h0000};
          3:       mem[b] = {16'hF800, 16'h0000};
          4:       mem[b] = {16'hE800, 16'h0000};
          5:       mem[b] = {16'h2000, 16'hE000};
          6:       mem[b] = {16'h0800, 16'h0000};
          default: mem[b] = {(j % 2 == 0) ? 16'h7000 : 16'h9000, 16'h0000};
        endcase
        j++;
      end
    end
  endtask

  // Run one symbol; optional stray start at pulse_at, optional reset at rst_at.
  task automatic sym(input string nm, input int mode, input logic q, input int pulse_at,
                     input int rst_at, input logic [191:0] e_res, input int e_nb,
                     input logic e_succ);
    int cyc, fin_cyc, n_fin;
    logic ce_fin, s_fin;
    logic [191:0] r_fin;
    fill(mode);
    @(negedge clk);
    start = 1'b1;
    qpsk  = q;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    chk({nm, "_c1_ad"}, 192'(ad), 192'd20);
    chk({nm, "_c1_busy"}, 192'(busy & ce & oce), 192'd1);
    fin_cyc = 0; n_fin = 0; ce_fin = 1'b1; s_fin = 1'b0; r_fin = '0;
    while (cyc < 200) begin
      if (finish) begin
        n_fin++;
        if (fin_cyc == 0) begin
          fin_cyc = cyc; ce_fin = ce; s_fin = success; r_fin = res;
        end
      end
      start = (cyc == pulse_at);
      if (cyc == rst_at) begin
        rst = 1'b1;
        #1;
        chk({nm, "_rst_busy_now"}, 192'(busy), 192'd0);
        @(posedge clk); #1;
        chk({nm, "_rst_busy"}, 192'(busy), 192'd0);
        chk({nm, "_rst_ce"}, 192'(ce | oce), 192'd0);
        chk({nm, "_rst_res"}, res, 192'd0);
        chk({nm, "_rst_ad"}, 192'(ad), 192'd0);
        rst = 1'b0;
        start = 1'b0;
        return;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk({nm, "_fin_cyc"}, 192'(fin_cyc), 192'd104);
    chk({nm, "_fin_cnt"}, 192'(n_fin), 192'd1);
    chk({nm, "_ce_at_fin"}, 192'(ce_fin), 192'd0);
    chk({nm, "_res"}, r_fin, e_res);
    chk({nm, "_succ_fin"}, 192'(s_fin), 192'(e_succ));
    chk({nm, "_nbits"}, 192'(nbits), 192'(e_nb));
    chk({nm, "_res_hold"}, res, e_res);
    chk({nm, "_succ_hold"}, 192'(success), 192'(e_succ));
    chk({nm, "_idle"}, 192'(busy | finish | ce), 192'd0);
  endtask

  logic [191:0] e_pay, e_p6;

  initial begin
    rst = 1'b1; start = 1'b0; qpsk = 1'b0;
    for (int b = 0; b < 2048; b++) mem[b] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy_fin_succ", 192'({busy, finish, success}), 192'd0);
    chk("rst_ce_oce", 192'({ce, oce}), 192'd0);
    chk("rst_ad", 192'(ad), 192'd0);
    chk("rst_res", res, 192'd0);
    chk("rst_nbits", 192'(nbits), 192'd0);
    rst = 1'b0;
    @(posedge clk);

    e_pay = '0;
    for (int k = 0; k < 12; k++) e_pay[8*k +: 8] = pay(k);
    e_p6 = ones(64);

    sym("bpsk_ones",   1, 1'b0, 0, 0, ones(96), 96, 1'b0);
    sym("bpsk_pay",    2, 1'b0, 0, 0, e_pay,    96, 1'b1);
    sym("ofs_ones",    3, 1'b0, 0, 0, ones(96), 96, 1'b0);
    sym("ofs_zeros",   4, 1'b0, 0, 0, 192'd0,   96, 1'b0);
    sym("pilot_track", 6, 1'b0, 0, 0, e_p6,     96, 1'b0);
    sym("wrap",        7, 1'b0, 0, 0, rep(8'h55, 12), 96, 1'b1);
`ifdef OFDM_DEMOD_QPSK_EN
    sym("qpsk",        5, 1'b1, 0, 0, rep(8'hAA, 24), 192, 1'b0);
`else
    sym("qpsk_off",    5, 1'b1, 0, 0, ones(96), 96, 1'b0);
`endif
    sym("start_busy",  2, 1'b0, 50, 0, e_pay, 96, 1'b1);
    sym("mid_rst",     1, 1'b0, 0, 60, ones(96), 96, 1'b0);
    @(posedge clk);
    sym("after_rst",   2, 1'b0, 0, 0, e_pay, 96, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ofdm_demod_param.md
# ofdm_demod_param

Parametrised OFDM symbol demodulator. It sequentially reads one symbol's FFT bins from the FFT output BSRAM and re-references every data subcarrier against the most recent pilot. It slices BPSK (1 bit/bin) or QPSK (2 bits/bin) into a packed result register and flags frame validity from sync bytes at both ends. It sits between the FFT-result BSRAM and the frame/packet layer.

## Interface
Parameters:
- ADDR_W, 11, BSRAM address width
- BIN_FIRST, 20, first bin read; always a pilot
- BIN_LAST, 120, last bin read; must itself be a pilot
- PILOT_SPACING, 33, pilots sit at BIN_FIRST and at BIN_FIRST+1+k·PILOT_SPACING, k≥0
- PILOT_AMP, 16'h4000, expected pilot real amplitude (Q1.15, 0.5)
- SYNC_BYTE, 8'h55, required first and last payload byte
- RD_LAT, 2, BSRAM read latency in cycles, 1 or 2

Derived: NB = BIN_LAST−BIN_FIRST+1; N_DATA = NB − pilot count (defaults: 101 bins, 5 pilots, 96 data). N_DATA must be a multiple of 8.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock
- rst  in  1  async active-high reset
- start  in  1  begin one symbol; sampled only in IDLE
- qpsk  in  1  mode, sampled with start; 0 = BPSK, 1 = QPSK
- busy  out  1  high from the cycle after accepted start until finish
- finish  out  1  one-cycle done pulse
- success  out  1  sync check result, held until next accepted start
- nbits  out  8  bits written: N_DATA or 2·N_DATA
- res  out  2·N_DATA  packed bits, held until next accepted start
- dout  in  32  BSRAM data; [31:16] = re, [15:0] = im, signed
- ce, oce  out  1  BSRAM enables
- ad  out  ADDR_W  BSRAM address

## Operation
- States: IDLE → ISSUE → DRAIN → DONE → IDLE.
- IDLE, start=1:
  - Clear res, success, nbits and the pilot references.
  - Latch qpsk.
  - Set ad=BIN_FIRST, ce=oce=1; go to ISSUE.
- ISSUE: ad increments by 1 each cycle. After ad=BIN_LAST has been presented, go to DRAIN.
- A valid/bin-index pipeline of depth RD_LAT tags each returning dout word.
- Pilot word:
  - pref_re = re − PILOT_AMP
  - pref_im = im
- Data word, with j = running bit index from 0:
  - Re bit: b = ~msb(re − pref_re).
  - QPSK adds an im bit: ~msb(im − pref_im).
  - Each bit is written to res[j ^ 7], then j increments. Bits are MSB-first within each byte; in QPSK the re bit precedes the im bit.
- All subtractions are 16-bit two's complement with wrap-around and no saturation. The decision is the MSB of the 16-bit difference.
- DRAIN: when the last word (BIN_LAST) has been consumed, drop ce/oce and go to DONE.
- DONE, one cycle:
  - finish=1; busy=0; nbits set.
  - success = (res[7:0]==SYNC_BYTE) && (top byte of used region == SYNC_BYTE). The top byte is res[N_DATA−1 -: 8] in BPSK and res[2·N_DATA−1 -: 8] in QPSK.
  - Return to IDLE.
- In BPSK, res bits above N_DATA−1 stay 0.
- start while busy is ignored, with no effect on the running symbol.
- rst asserted at any time, including mid-symbol: immediate return to IDLE with all outputs at reset values.
- Reset values: finish=0, success=0, busy=0, res=0, nbits=0, ce=0, oce=0, ad=0.

## Timing
- Cycle 0: start accepted.
- Cycle 1: ad=BIN_FIRST, ce=oce=1, busy=1.
- Cycle k: ad = BIN_FIRST+k−1, for k = 1..NB.
- Word for the address presented at cycle c is consumed at edge c+RD_LAT.
- finish pulse at cycle NB+RD_LAT+1 (defaults: cycle 104). ce/oce are low from the same cycle.
- A new start is accepted at the earliest in the cycle after finish, so the minimum symbol period is NB+RD_LAT+2 cycles.

## Configuration
- OFDM_DEMOD_QPSK_EN defined: qpsk input honoured; QPSK produces 2·N_DATA bits.
- Undefined: qpsk is ignored and treated as 0, the im path and pref_im are not built, and res[2·N_DATA−1:N_DATA] is tied to 0.

## Test plan
- BPSK, defaults, all pilots re=0x4000, all data re=0x6000 → res[95:0]=all 1, res[191:96]=0, nbits=96, success=0, finish at cycle 104.
- BPSK, data encoding payload 0x55, 0xA5×10, 0x55 (byte 0 first, MSB-first) with re=±0x2000 → res[7:0]=0x55, res[95:88]=0x55, success=1.
- Pilot offset: pilot re=0x3000 (pref_re=−0x1000), data re=−0x0800 → every bit 1 (diff=+0x0800). Then data re=−0x1800 → every bit 0.
- QPSK with macro defined: re=+0x2000, im=−0x2000 on all data, pilots im=0 → bits alternate 1,0, res[7:0]=0xAA, nbits=192, success=0.
- start pulsed again at cycle 50 → ignored; finish once at 104 with unchanged res.
- rst asserted at cycle 60 → busy=0, ce=0, res=0 next cycle. A new start then completes normally with finish at cycle 104 relative to that start.
